// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   ID-stage register hazard tracker. Every in-flight register write holds a
//   per-register countdown of the cycles left until its result is visible in
//   the register file. An ID instruction that reads a register with a pending
//   write raises stall. Stall freezes IF/ID and inserts a bubble into ID/EXE.
//
//   Optional feature macro: FORWARDING_EN
//     When it is defined, a count of 1 means the result is already on the bypass
//     network. That case raises fwd_hit instead of a hazard.
//     When it is undefined, any nonzero count is a hazard and there is no
//     fwd_hit port.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous reset, active low
//   id_valid     instruction present in ID
//   id_src       source addresses, src k at [k*REG_AW +: REG_AW]
//   id_src_used  bit k set: src k is really read
//   id_wb_en     instruction writes id_dest
//   id_dest      destination register
//   id_lat       producer latency in cycles, 0 = untracked
//   flush        kill the ID instruction this cycle
//   stall        hold IF/ID and insert a bubble (combinational)
//   src_hazard   per-source hazard flags (combinational)
//   busy_vec     bit r set: register r has a pending write (from flops)
//   stall_cnt    saturating count of stalled cycles
//   fwd_hit      (FORWARDING_EN only) per-source bypass select
module hazard_scoreboard #(
  parameter int REG_AW   = 4,
  parameter int NUM_SRC  = 2,
  parameter int MAX_LAT  = 3,
  parameter int STALL_CW = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      id_wb_en,
  input  logic [REG_AW-1:0]         id_dest,
  input  logic [3:0]                id_lat,
  input  logic                      flush,
  output logic                      stall,
  output logic [NUM_SRC-1:0]        src_hazard,
  output logic [2**REG_AW-1:0]      busy_vec,
  output logic [STALL_CW-1:0]       stall_cnt
`ifdef FORWARDING_EN
  ,
  output logic [NUM_SRC-1:0]        fwd_hit
`endif
);

  localparam int NREG = 2**REG_AW;
  localparam int CW   = $clog2(MAX_LAT + 1);

  logic [CW-1:0] cnt     [NREG];
  logic [CW-1:0] cnt_nxt [NREG];
  logic [CW-1:0] src_cnt [NUM_SRC];
  logic [CW-1:0] lat_eff;
  logic          issue;

  always_comb begin
    if (id_lat > 4'(MAX_LAT)) lat_eff = CW'(MAX_LAT);
    else                      lat_eff = CW'(id_lat);
  end

  // An unused source never indexes the counters. This keeps X addresses on an
  // unused source from leaking into the hazard logic.
  always_comb begin
    src_hazard = '0;
`ifdef FORWARDING_EN
    fwd_hit = '0;
`endif
    for (int k = 0; k < NUM_SRC; k++) begin
      src_cnt[k] = '0;
      if (id_src_used[k]) begin
        src_cnt[k] = cnt[id_src[k*REG_AW +: REG_AW]];
`ifdef FORWARDING_EN
        src_hazard[k] = id_valid && (src_cnt[k] > CW'(1));
        fwd_hit[k]    = (src_cnt[k] == CW'(1));
`else
        src_hazard[k] = id_valid && (src_cnt[k] != '0);
`endif
      end
    end
  end

  // The hazard check uses the counters before this cycle's update, so an
  // instruction never hazards against its own write.
  assign stall = (|src_hazard) & ~flush;
  assign issue = id_valid & id_wb_en & (id_lat != 4'd0) & ~stall & ~flush;

  // Each counter counts down by one. An issue to the same register takes the
  // larger of the decremented value and the new latency. A younger write
  // therefore never makes a pending write look finished too early.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_nxt[r] = (cnt[r] != '0) ? cnt[r] - CW'(1) : '0;
      if (issue && (id_dest == REG_AW'(r)) && (lat_eff > cnt_nxt[r]))
        cnt_nxt[r] = lat_eff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) busy_vec[r] = (cnt[r] != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + STALL_CW'(1);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int REG_AW   = 4;
  localparam int NUM_SRC  = 2;
  localparam int MAX_LAT  = 3;
  localparam int STALL_CW = 4;
  localparam int NREG     = 16;
  localparam int SC_MAX   = 15;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [7:0]  id_src;
  logic [1:0]  id_src_used;
  logic        id_wb_en;
  logic [3:0]  id_dest;
  logic [3:0]  id_lat;
  logic        flush;
  logic        stall;
  logic [1:0]  src_hazard;
  logic [15:0] busy_vec;
  logic [3:0]  stall_cnt;
`ifdef FORWARDING_EN
  logic [1:0]  fwd_hit;
`endif

  hazard_scoreboard #(
    .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MAX_LAT(MAX_LAT), .STALL_CW(STALL_CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_lat(id_lat), .flush(flush), .stall(stall), .src_hazard(src_hazard),
    .busy_vec(busy_vec), .stall_cnt(stall_cnt)
`ifdef FORWARDING_EN
    , .fwd_hit(fwd_hit)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model. For each register, ready[r] is the first cycle in which
  // a reader sees the final value. The model tracks absolute cycle numbers
  // rather than countdown values.
  int cyc = 0;
  int ready [NREG];
  int model_sc = 0;

  function automatic logic [1:0] m_haz();
    logic [1:0] h;
    int r;
    h = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      r = int'(id_src[k*4 +: 4]);
      if (id_valid && id_src_used[k])
        h[k] = FWD ? (cyc < ready[r] - 1) : (cyc < ready[r]);
    end
    return h;
  endfunction

  function automatic logic m_stall();
    return (|m_haz()) && !flush;
  endfunction

  function automatic logic [15:0] m_busy();
    logic [15:0] b;
    for (int r = 0; r < NREG; r++) b[r] = (cyc < ready[r]);
    return b;
  endfunction

  function automatic logic [1:0] m_fwd();
    logic [1:0] f;
    int r;
    f = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      r = int'(id_src[k*4 +: 4]);
      if (id_src_used[k]) f[k] = (cyc == ready[r] - 1);
    end
    return f;
  endfunction

  // Advances the model by one clock using the current inputs, then moves to
  // 1 time unit after the next rising edge.
  task automatic advance();
    logic st;
    int le;
    st = m_stall();
    if (id_valid && id_wb_en && id_lat != 0 && !st && !flush) begin
      le = (int'(id_lat) > MAX_LAT) ? MAX_LAT : int'(id_lat);
      if (cyc + 1 + le > ready[id_dest]) ready[id_dest] = cyc + 1 + le;
    end
    if (st && model_sc < SC_MAX) model_sc++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_idle();
    id_valid = 0; id_src = '0; id_src_used = '0; id_wb_en = 0;
    id_dest = '0; id_lat = '0; flush = 0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) ready[r] = 0;
    model_sc = 0;
  endtask

  task automatic issue_only(input int dest, input int lat);
    set_idle();
    id_valid = 1; id_wb_en = 1; id_dest = 4'(dest); id_lat = 4'(lat);
  endtask

  task automatic test_reset();
    issue_only(4, 3);
    advance();
    #2;
    id_valid = 1; id_src = 8'h44; id_src_used = 2'b11; id_wb_en = 1;
    id_dest = 4'($urandom); id_lat = 4'($urandom); flush = 0;
    rst_n = 0;
    model_reset();
    #1;
    checks++; if (busy_vec !== 16'h0) begin failures++; $display("FAIL reset_busy got=%h exp=0", busy_vec); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (stall_cnt !== 4'h0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (src_hazard !== 2'b00) begin failures++; $display("FAIL reset_src_hazard got=%b exp=00", src_hazard); end
    @(posedge clk); #1; cyc++;
    checks++; if (busy_vec !== 16'h0) begin failures++; $display("FAIL reset_hold_busy got=%h exp=0", busy_vec); end
    rst_n = 1;
    set_idle();
  endtask

  task automatic test_stall_release();
    int nst;
    logic released;
    nst = 0;
    released = 0;
    issue_only(3, 3);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL issue_no_stall got=%b exp=0", stall); end
    advance();
    set_idle();
    id_valid = 1; id_src = 8'h03; id_src_used = 2'b01;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (stall !== m_stall()) begin failures++; $display("FAIL raw_stall cyc=%0d got=%b exp=%b", cyc, stall, m_stall()); end
      if (stall === 1'b1) nst++;
`ifdef FORWARDING_EN
      if (stall === 1'b0 && !released) begin
        released = 1;
        checks++; if (fwd_hit[0] !== 1'b1) begin failures++; $display("FAIL fwd_on_release got=%b exp=1", fwd_hit[0]); end
      end
`endif
      advance();
    end
    checks++; if (nst != (FWD ? 2 : 3)) begin failures++; $display("FAIL raw_stall_cycles got=%0d exp=%0d", nst, FWD ? 2 : 3); end
    checks++; if (stall_cnt !== (FWD ? 4'd2 : 4'd3)) begin failures++; $display("FAIL raw_stall_cnt got=%0d exp=%0d", stall_cnt, FWD ? 2 : 3); end
    set_idle();
  endtask

  task automatic test_src_used();
    issue_only(3, 3);
    advance();
    set_idle();
    id_valid = 1; id_src = 8'h31; id_src_used = 2'b01;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL unused_src_stall got=%b exp=0", stall); end
    id_src_used = 2'b11;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL used_src_stall got=%b exp=1", stall); end
    checks++; if (src_hazard !== 2'b10) begin failures++; $display("FAIL used_src_hazard got=%b exp=10", src_hazard); end
    advance();
    set_idle();
    for (int i = 0; i < 4; i++) advance();
  endtask

  task automatic test_waw();
    int nb;
    issue_only(5, 3);
    advance();
    issue_only(5, 1);
    advance();
    set_idle();
    nb = 0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (busy_vec !== m_busy()) begin failures++; $display("FAIL waw_busy cyc=%0d got=%h exp=%h", cyc, busy_vec, m_busy()); end
      if (busy_vec[5] === 1'b1) nb++;
      advance();
    end
    checks++; if (nb != 2) begin failures++; $display("FAIL waw_busy_cycles got=%0d exp=2", nb); end
    issue_only(6, 9);
    advance();
    set_idle();
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy_vec[6] === 1'b1) nb++;
      advance();
    end
    checks++; if (nb != 3) begin failures++; $display("FAIL lat_clamp_cycles got=%0d exp=3", nb); end
  endtask

  task automatic test_flush_and_midreset();
    issue_only(7, 3);
    advance();
    set_idle();
    id_valid = 1; id_src = 8'h07; id_src_used = 2'b01; id_wb_en = 1;
    id_dest = 4'd8; id_lat = 4'd2; flush = 1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall); end
    advance();
    set_idle();
    checks++; if (busy_vec[8] !== 1'b0) begin failures++; $display("FAIL flush_no_load got=%b exp=0", busy_vec[8]); end
    checks++; if (busy_vec !== m_busy()) begin failures++; $display("FAIL flush_keep_count got=%h exp=%h", busy_vec, m_busy()); end
    issue_only(9, 3);
    advance();
    set_idle();
    rst_n = 0;
    model_reset();
    #1;
    checks++; if (busy_vec !== 16'h0) begin failures++; $display("FAIL midreset_busy got=%h exp=0", busy_vec); end
    rst_n = 1;
    advance();
  endtask

  task automatic test_saturate();
    rst_n = 0; model_reset(); #1; rst_n = 1;
    for (int rep = 0; rep < 8; rep++) begin
      issue_only(2, 3);
      advance();
      set_idle();
      id_valid = 1; id_src = 8'h22; id_src_used = 2'b11;
      for (int i = 0; i < 4; i++) begin
        #1;
        checks++; if (stall_cnt !== 4'(model_sc)) begin failures++; $display("FAIL sat_stall_cnt cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, model_sc); end
        advance();
      end
    end
    checks++; if (stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_final got=%0d exp=15", stall_cnt); end
    set_idle();
  endtask

  task automatic test_random();
    rst_n = 0; model_reset(); #1; rst_n = 1;
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_src = 8'($urandom_range(0, 255));
      id_src_used = 2'($urandom_range(0, 3));
      id_wb_en = ($urandom_range(0, 3) != 0);
      id_dest = 4'($urandom_range(0, 7));
      id_lat = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      flush = ($urandom_range(0, 7) == 0);
      #1;
      checks++; if (src_hazard !== m_haz()) begin failures++; $display("FAIL rnd_src_hazard cyc=%0d got=%b exp=%b", cyc, src_hazard, m_haz()); end
      checks++; if (stall !== m_stall()) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, stall, m_stall()); end
      checks++; if (busy_vec !== m_busy()) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%h exp=%h", cyc, busy_vec, m_busy()); end
      checks++; if (stall_cnt !== 4'(model_sc)) begin failures++; $display("FAIL rnd_stall_cnt cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, model_sc); end
`ifdef FORWARDING_EN
      checks++; if (fwd_hit !== m_fwd()) begin failures++; $display("FAIL rnd_fwd_hit cyc=%0d got=%b exp=%b", cyc, fwd_hit, m_fwd()); end
`endif
      advance();
    end
    set_idle();
  endtask

  initial begin
    rst_n = 0;
    set_idle();
    model_reset();
    #12;
    rst_n = 1;
    @(posedge clk); #1; cyc++;
    test_reset();
    test_stall_release();
    test_src_used();
    test_waw();
    test_flush_and_midreset();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
